cbus_sram_responder: RTL and testbench
======================================

Name: cbus_sram_responder

Overview:
- Memory-side responder for the cache bus (cbus): accepts burst read/write requests from a cbus initiator such as a data or instruction cache, and returns data beats with ready/last handshakes.
- Backed by an internal word-addressed SRAM array. Used as the on-chip memory model in cache unit benches and as the scratch SRAM behind the cache in small SoC builds.
- Programmable first-beat latency and periodic stall bubbles exercise initiator FSMs.

Parameters:
- ADDR_WIDTH, 12: word-address bits; array holds 2^ADDR_WIDTH 64-bit words.
- READ_LATENCY, 2: idle cycles between request acceptance and the first beat (0 allowed).
- STALL_EVERY, 0: after every STALL_EVERY beats, insert one cycle with ready=0; 0 disables.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- creq  in  cbus_req_t  request fields:
  - valid
  - is_write
  - size (msize_t)
  - addr (64)
  - strobe (8)
  - data (64)
  - len (mlen_t; beats = len+1)
  - burst (AXI_BURST_FIXED / INCR / WRAP)
- cresp  out  cbus_resp_t  response fields:
  - ready: beat transferred this cycle
  - last: final beat
  - data (64): read data

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high.
  - State goes to IDLE; beat counter, latency counter and stall counter clear.
  - cresp.ready=0, cresp.last=0, cresp.data=0.
  - SRAM contents are not cleared.
  - Reset mid-burst aborts the burst; no further writes occur.
- Protocol rules (initiator side, relied on):
  - creq.valid and all fields except data/strobe stay stable from acceptance until the beat with last.
  - Write data/strobe for the current beat are valid whenever ready could be high.
- States:
  - IDLE: cresp all zero. If creq.valid=1, latch addr word index (addr[ADDR_WIDTH+2:3]), len, burst, is_write. Go to WAIT if READ_LATENCY>0, else BURST.
  - WAIT: count READ_LATENCY cycles with ready=0, then go to BURST.
  - BURST: ready=1 each cycle, except stall-bubble cycles. Each ready cycle is one beat; the beat counter increments.
    - last=1 together with ready on beat index len.
    - Next state after the last beat: IDLE.
- Latency: if valid is first high in cycle k (responder in IDLE), the first ready is in cycle k+1+READ_LATENCY. With STALL_EVERY=0, a len=15 burst ends with last in cycle k+16+READ_LATENCY.
- Back-to-back requests: after last, the responder spends one IDLE cycle. If valid is still high there, this is a new request; it is latched with the current fields.
- Beat address (word index, ADDR_WIDTH-bit arithmetic, modulo array size):
  - FIXED: base.
  - INCR: base+beat.
  - WRAP: low log2(len+1) bits = (base_low+beat) mod (len+1); high bits from base.
  - len+1 must be a power of two for WRAP.
- Read beats: cresp.data = SRAM[beat address], combinational in the ready cycle. cresp.data=0 when ready=0.
- Write beats: on the clock edge ending a ready cycle, each byte with strobe[i]=1 takes creq.data[8i+7:8i]. Bytes with strobe[i]=0 are unchanged. cresp.data=0 throughout a write.
- Size field: narrow sizes (<MSIZE8) are handled purely through strobe. The address's low 3 bits are ignored for indexing.
- Stall bubbles:
  - A stall counter counts ready beats within a burst.
  - When the count reaches STALL_EVERY and further beats remain, the next cycle has ready=0 and the counter clears.
  - No bubble follows the last beat.
- Abort: if creq.valid=0 during WAIT or BURST, return to IDLE next cycle. ready/last are 0 in that cycle, and no write happens.
- Address overflow: indices beyond the array wrap modulo 2^ADDR_WIDTH; no error response exists.

Test Plan:
- Preloaded SRAM[i]=i*0x1111, READ_LATENCY=2, INCR read addr=0x80 len=15, valid in cycle 0:
  - ready is low in cycles 1-2, high in cycles 3-18.
  - data goes 0x11110, 0x12221, … (words 16..31).
  - last is only in cycle 18, then IDLE.
- INCR write addr=0x100 len=15, strobe=0xFF, data=0xA0+beat; then a read of the same line:
  - the read returns 0xA0..0xAF in order.
  - neighbouring words 31 and 48 are unchanged.
- Single-beat write: len=0, strobe=0x0F, data=0xDEADBEEF_CAFEF00D to a word holding 0x1122334455667788:
  - a subsequent read returns 0x11223344CAFEF00D.
  - ready and last are asserted together on the single beat.
- STALL_EVERY=4, READ_LATENCY=0, len=15 read:
  - ready pattern is 1111 0 1111 0 1111 0 1111.
  - last is on the 16th ready; 19 cycles from first ready to last.
- WRAP read with base word 0x0D, len=3:
  - beats return words 0x0D, 0x0E, 0x0F, 0x0C.
- Timing edge cases:
  - Reset asserted at beat 5 of a 16-beat write: ready/last go 0 next cycle, words 5..15 remain old, and the next request is served normally.
  - Valid held high directly after last (a writeback followed by an allocate): the second request is accepted in the IDLE cycle and its first ready arrives READ_LATENCY+1 cycles later.

Source files
------------

// File: rtl/cbus_sram_responder.sv
// Cache-bus memory responder: burst reads/writes against an internal 64-bit SRAM
// with programmable first-beat latency and periodic stall bubbles.
package cbus_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    mlen_t       len;
    axi_burst_t  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_sram_responder
  import cbus_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2,
  parameter int STALL_EVERY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);
  localparam int DEPTH   = 1 << ADDR_WIDTH;
  localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int STALL_W = (STALL_EVERY > 0) ? $clog2(STALL_EVERY + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  mlen_t                   len_reg;
  axi_burst_t              burst_reg;
  logic                    write_reg;
  mlen_t                   beat_reg;
  logic [LAT_W-1:0]        lat_reg;
  logic [STALL_W-1:0]      stall_reg;
  logic                    bubble_reg;

  logic                    beat_ready;
  logic                    beat_last;
  logic [ADDR_WIDTH-1:0]   beat_w;
  logic [ADDR_WIDTH-1:0]   mask_w;
  logic [ADDR_WIDTH-1:0]   beat_addr;
  logic [63:0]             rd_word;

  // Size and the byte offset within a word play no part in indexing; narrow writes use strobe.
  logic unused_bits;
  assign unused_bits = ^{creq.size, creq.addr[63:ADDR_WIDTH+3], creq.addr[2:0]};

  assign beat_w = ADDR_WIDTH'(beat_reg);
  assign mask_w = ADDR_WIDTH'(len_reg);

  // WRAP relies on len+1 being a power of two, so len itself is the wrap mask.
  always_comb begin
    case (burst_reg)
      AXI_BURST_INCR: beat_addr = base_reg + beat_w;
      AXI_BURST_WRAP: beat_addr = (base_reg & ~mask_w) | ((base_reg + beat_w) & mask_w);
      default:        beat_addr = base_reg;
    endcase
  end

  assign beat_ready = (state_reg == BURST) && !bubble_reg && creq.valid;
  assign beat_last  = beat_ready && (beat_reg == len_reg);

  // One byte-wide array per lane maps onto byte-enabled block RAM.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge clk) begin
        if (beat_ready && write_reg && !reset && creq.strobe[gi]) begin
          lane_mem[beat_addr] <= creq.data[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[beat_addr];
    end
  endgenerate

  always_comb begin
    cresp       = '0;
    cresp.ready = beat_ready;
    cresp.last  = beat_last;
    cresp.data  = (beat_ready && !write_reg) ? rd_word : 64'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      lat_reg    <= '0;
      stall_reg  <= '0;
      bubble_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (creq.valid) begin
            base_reg   <= creq.addr[ADDR_WIDTH+2:3];
            len_reg    <= creq.len;
            burst_reg  <= creq.burst;
            write_reg  <= creq.is_write;
            beat_reg   <= '0;
            lat_reg    <= '0;
            stall_reg  <= '0;
            bubble_reg <= 1'b0;
            state_reg  <= (READ_LATENCY > 0) ? WAIT : BURST;
          end
        end
        WAIT: begin
          if (!creq.valid) begin
            state_reg <= IDLE;
          end else if (lat_reg == LAT_W'(READ_LATENCY - 1)) begin
            state_reg <= BURST;
          end else begin
            lat_reg <= lat_reg + LAT_W'(1);
          end
        end
        BURST: begin
          if (!creq.valid) begin
            state_reg <= IDLE;
          end else if (bubble_reg) begin
            bubble_reg <= 1'b0;
          end else if (beat_reg == len_reg) begin
            state_reg <= IDLE;
          end else begin
            beat_reg <= beat_reg + 8'd1;
            // A bubble only ever follows a non-final beat, so none trails the last.
            if (STALL_EVERY > 0 && stall_reg == STALL_W'(STALL_EVERY - 1)) begin
              stall_reg  <= '0;
              bubble_reg <= 1'b1;
            end else begin
              stall_reg <= stall_reg + STALL_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cbus_sram_responder.sv
// Bench for cbus_sram_responder: directed vector table, hand-written corner sequences,
// and randomized bursts against a transaction-level timing and memory model.
module tb_cbus_sram_responder;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  int         sel;
  cbus_req_t  creq, creq_a, creq_b;
  cbus_resp_t resp_a, resp_b;

  int tests, fails;

  logic [63:0] mem_a [4096];
  logic [63:0] mem_b [64];
  logic [63:0] wbeats [256];

  always #5 clk = ~clk;

  always_comb begin
    creq_a       = creq;
    creq_a.valid = creq.valid && (sel == 0);
    creq_b       = creq;
    creq_b.valid = creq.valid && (sel == 1);
  end

  cbus_sram_responder #(.ADDR_WIDTH(12), .READ_LATENCY(2), .STALL_EVERY(0)) dut_a (
    .clk(clk), .reset(reset), .creq(creq_a), .cresp(resp_a)
  );

  cbus_sram_responder #(.ADDR_WIDTH(6), .READ_LATENCY(0), .STALL_EVERY(4)) dut_b (
    .clk(clk), .reset(reset), .creq(creq_b), .cresp(resp_b)
  );

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int beat_word(input int size, input logic [63:0] addr, input int len,
                                   input axi_burst_t bt, input int b);
    longint unsigned base;
    int lo, n;
    base = (addr >> 3) % longint'(size);
    n    = len + 1;
    lo   = int'(base) % n;
    case (bt)
      AXI_BURST_INCR: return (int'(base) + b) % size;
      AXI_BURST_WRAP: return int'(base) - lo + (lo + b) % n;
      default:        return int'(base);
    endcase
  endfunction

  function automatic logic [63:0] model_rd(input int s, input int w);
    return s ? mem_b[w] : mem_a[w];
  endfunction

  task automatic model_wr(input int s, input int w, input logic [7:0] strb, input logic [63:0] d);
    logic [63:0] cur;
    cur = model_rd(s, w);
    for (int i = 0; i < 8; i++) if (strb[i]) cur[8*i +: 8] = d[8*i +: 8];
    if (s) mem_b[w] = cur;
    else mem_a[w] = cur;
  endtask

  // Entry and exit are just after a rising edge. Cycle 0 is the IDLE cycle with valid first high.
  task automatic run_burst(input int s, input bit wr, input logic [63:0] addr, input int len,
                           input axi_burst_t bt, input logic [7:0] strb, input bit keep,
                           input int abort_beat, input bit abort_rst,
                           output int first_rdy, output int last_cyc, output logic [63:0] first_data);
    int rl, se, size, beat, last_off, off, w;
    bit er, el, aborted;
    logic [63:0] ed;
    cbus_resp_t r;
    rl = s ? 0 : 2;
    se = s ? 4 : 0;
    size = s ? 64 : 4096;
    last_off = 1 + rl + len + (se > 0 ? len / se : 0);
    first_rdy = -1; last_cyc = -1; first_data = '0; beat = 0; aborted = 0;
    for (int c = 0; c <= last_off && !aborted; c++) begin
      off = 1 + rl + beat + (se > 0 ? beat / se : 0);
      er = (c == off);
      el = er && (beat == len);
      w = beat_word(size, addr, len, bt, beat);
      #1;
      sel = s;
      creq.valid = 1'b1; creq.is_write = wr; creq.size = MSIZE8; creq.addr = addr;
      creq.len = 8'(len); creq.burst = bt; creq.strobe = strb; creq.data = wbeats[beat];
      if (er && beat == abort_beat) begin
        aborted = 1;
        if (abort_rst) reset = 1'b1;
        else creq.valid = 1'b0;
        er = 0; el = 0;
      end
      @(negedge clk);
      r = s ? resp_b : resp_a;
      ed = (er && !wr) ? model_rd(s, w) : 64'h0;
      if (!(aborted && abort_rst))
        check($sformatf("dut%0d cycle %0d beat %0d", s, c, beat), {r.ready, r.last, r.data}, {er, el, ed});
      if (r.ready && first_rdy < 0) begin first_rdy = c; first_data = r.data; end
      if (r.last) last_cyc = c;
      if (er) begin
        if (wr) model_wr(s, w, strb, wbeats[beat]);
        beat++;
      end
      @(posedge clk);
    end
    if (!keep) begin
      #1;
      reset = 1'b0;
      creq.valid = 1'b0;
      @(negedge clk);
      r = s ? resp_b : resp_a;
      check($sformatf("dut%0d idle after burst", s), {r.ready, r.last, r.data}, 66'h0);
      @(posedge clk);
    end
  endtask

  typedef struct {
    int          s;
    bit          wr;
    logic [63:0] addr;
    int          len;
    axi_burst_t  bt;
    logic [7:0]  strb;
    logic [63:0] wbase;
    int          exp_first;
    int          exp_last;
    logic [63:0] exp_data;
  } vec_t;

  initial begin
    vec_t vecs [14];
    int fr, lc, len, ab;
    logic [63:0] fd;
    bit kp;
    axi_burst_t bt;

    vecs[0]  = '{0, 0, 64'h80,     15, AXI_BURST_INCR,  8'hFF, 64'h0,                 3, 18, 64'h11110};
    vecs[1]  = '{0, 1, 64'h100,    15, AXI_BURST_INCR,  8'hFF, 64'hA0,                3, 18, 64'h0};
    vecs[2]  = '{0, 0, 64'h100,    15, AXI_BURST_INCR,  8'hFF, 64'h0,                 3, 18, 64'hA0};
    vecs[3]  = '{0, 0, 64'hF8,      0, AXI_BURST_INCR,  8'hFF, 64'h0,                 3,  3, 64'h2110F};
    vecs[4]  = '{0, 0, 64'h180,     0, AXI_BURST_INCR,  8'hFF, 64'h0,                 3,  3, 64'h33330};
    vecs[5]  = '{0, 1, 64'h200,     0, AXI_BURST_INCR,  8'hFF, 64'h1122334455667788,  3,  3, 64'h0};
    vecs[6]  = '{0, 1, 64'h200,     0, AXI_BURST_INCR,  8'h0F, 64'hDEADBEEFCAFEF00D,  3,  3, 64'h0};
    vecs[7]  = '{0, 0, 64'h200,     0, AXI_BURST_INCR,  8'hFF, 64'h0,                 3,  3, 64'h11223344CAFEF00D};
    vecs[8]  = '{1, 0, 64'h0,      15, AXI_BURST_INCR,  8'hFF, 64'h0,                 1, 19, 64'h0};
    vecs[9]  = '{0, 0, 64'h68,      3, AXI_BURST_WRAP,  8'hFF, 64'h0,                 3,  6, 64'hDDDD};
    vecs[10] = '{0, 0, 64'h2D,      3, AXI_BURST_FIXED, 8'hFF, 64'h0,                 3,  6, 64'h5555};
    vecs[11] = '{1, 0, 64'h1001F0,  3, AXI_BURST_INCR,  8'hFF, 64'h0,                 1,  4, 64'h4221E};
    vecs[12] = '{1, 1, 64'h40,      7, AXI_BURST_INCR,  8'hFF, 64'h5000,              1,  9, 64'h0};
    vecs[13] = '{1, 0, 64'h40,      7, AXI_BURST_INCR,  8'hFF, 64'h0,                 1,  9, 64'h5000};

    tests = 0; fails = 0; sel = 0; creq = '0; reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dut0", {resp_a.ready, resp_a.last, resp_a.data}, 66'h0);
    check("reset dut1", {resp_b.ready, resp_b.last, resp_b.data}, 66'h0);
    reset = 1'b0;
    @(posedge clk);

    // Preload every word with index*0x1111 through ordinary write bursts.
    for (int s = 0; s < 2; s++) begin
      for (int base = 0; base < (s ? 64 : 4096); base += 256) begin
        len = (s ? 64 : 256) - 1;
        for (int b = 0; b <= len; b++) wbeats[b] = 64'(base + b) * 64'h1111;
        run_burst(s, 1, 64'(base) << 3, len, AXI_BURST_INCR, 8'hFF, 0, -1, 0, fr, lc, fd);
      end
    end

    for (int i = 0; i < 14; i++) begin
      for (int b = 0; b < 256; b++) wbeats[b] = vecs[i].wbase + 64'(b);
      run_burst(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].bt, vecs[i].strb,
                0, -1, 0, fr, lc, fd);
      check($sformatf("vec%0d first ready", i), 66'(fr), 66'(vecs[i].exp_first));
      check($sformatf("vec%0d last cycle", i), 66'(lc), 66'(vecs[i].exp_last));
      check($sformatf("vec%0d first data", i), 66'(fd), 66'(vecs[i].exp_data));
    end

    // Writeback immediately followed by an allocate on the same line.
    for (int b = 0; b < 256; b++) wbeats[b] = 64'hB0 + 64'(b);
    run_burst(0, 1, 64'h300, 3, AXI_BURST_INCR, 8'hFF, 1, -1, 0, fr, lc, fd);
    run_burst(0, 0, 64'h300, 3, AXI_BURST_INCR, 8'hFF, 0, -1, 0, fr, lc, fd);
    check("back-to-back first ready", 66'(fr), 66'd3);
    check("back-to-back first data", 66'(fd), 66'hB0);

    // Reset at beat 5 of a 16-beat write, then a normal read of the line.
    for (int b = 0; b < 256; b++) wbeats[b] = 64'hC00 + 64'(b);
    run_burst(0, 1, 64'h400, 15, AXI_BURST_INCR, 8'hFF, 0, 5, 1, fr, lc, fd);
    run_burst(0, 0, 64'h400, 15, AXI_BURST_INCR, 8'hFF, 0, -1, 0, fr, lc, fd);
    check("post-reset read first data", 66'(fd), 66'hC00);
    check("post-reset read last cycle", 66'(lc), 66'd18);

    // Valid dropped mid-burst on the stalling instance.
    for (int b = 0; b < 256; b++) wbeats[b] = 64'hD00 + 64'(b);
    run_burst(1, 1, 64'h80, 15, AXI_BURST_INCR, 8'hFF, 0, 6, 0, fr, lc, fd);
    run_burst(1, 0, 64'h80, 15, AXI_BURST_INCR, 8'hFF, 0, -1, 0, fr, lc, fd);
    check("post-abort read last cycle", 66'(lc), 66'd19);

    for (int i = 0; i < 60; i++) begin
      bt = axi_burst_t'($urandom_range(0, 2));
      if (bt == AXI_BURST_WRAP) len = (1 << $urandom_range(0, 4)) - 1;
      else len = $urandom_range(0, 15);
      for (int b = 0; b < 256; b++) wbeats[b] = {$urandom, $urandom};
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      kp = (ab < 0) && ($urandom_range(0, 3) == 0);
      run_burst($urandom_range(0, 1), 1'($urandom_range(0, 1)), {$urandom, $urandom}, len, bt,
                8'($urandom), kp, ab, 0, fr, lc, fd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
